mlp_layer_scheduler: RTL and testbench

Sequencing controller for the four-layer fully-connected CIM pipeline (784-784-500-250-10). It generates the start, CIM-busy, activation-start and next-busy handshakes for each `fc_layer` instance, and hands a frame token from layer to layer so that different frames occupy different layers at the same time. It sits beside the layer-array top level and faces a frame source upstream and a result sink downstream.

---
 rtl/mlp_sched_pkg.sv | 21 ++
 rtl/layer_seq_fsm.sv | 96 +++++++++
 rtl/mlp_layer_scheduler.sv | 96 +++++++++
 tb/tb_mlp_layer_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_sched_pkg.sv
// Shared types and constants for the four-layer CIM sequencing controller.
// Layer widths follow the 784-784-500-250-10 fully-connected pipeline.
package mlp_sched_pkg;

  localparam int NUM_LAYERS   = 4;
  localparam int OUT_CYCLES_1 = 784;
  localparam int OUT_CYCLES_2 = 500;
  localparam int OUT_CYCLES_3 = 250;
  localparam int OUT_CYCLES_4 = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD_HI,
    S_LOAD,
    S_CIM,
    S_FUNC,
    S_WB
  } layer_state_t;

endpackage

// File: rtl/layer_seq_fsm.sv
// Per-layer sequencer: start, load, crossbar MVM, activation and writeback.
// Handshake outputs are registered from the next state.
module layer_seq_fsm
  import mlp_sched_pkg::*;
#(
  parameter int CIM_CYCLES = 16,
  parameter int OUT_CYCLES = 784,
  parameter int CNT_W      = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pend_i,
  input  logic layer_busy_i,
  input  logic next_busy_i,
  output logic idle_o,
  output logic wb_done_o,
  output logic start_o,
  output logic cim_busy_o,
  output logic func_start_o
);

  localparam logic [CNT_W-1:0] CIM_LOAD = CNT_W'(CIM_CYCLES - 1);
  localparam logic [CNT_W-1:0] OUT_LOAD = CNT_W'(OUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  layer_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             cim_q, cim_d;
  logic             fs_q, fs_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      cim_q   <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      cim_q   <= cim_d;
      fs_q    <= fs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pend_i) state_d = S_START;
      end
      S_START: state_d = S_LOAD_HI;
      S_LOAD_HI: begin
        if (layer_busy_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!layer_busy_i) begin
          state_d = S_CIM;
          cnt_d   = CIM_LOAD;
        end
      end
      S_CIM: begin
        if (cnt_q == '0) state_d = S_FUNC;
        else cnt_d = cnt_q - ONE;
      end
      // Writeback only into a free downstream buffer.
      S_FUNC: begin
        if (!next_busy_i) begin
          state_d = S_WB;
          cnt_d   = OUT_LOAD;
        end
      end
      S_WB: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start_d   = (state_d == S_START);
    cim_d     = (state_d == S_CIM);
    fs_d      = (state_q == S_FUNC) && (state_d == S_WB);
    wb_done_o = (state_q == S_WB) && (state_d == S_IDLE);
  end

  assign idle_o       = (state_q == S_IDLE);
  assign start_o      = start_q;
  assign cim_busy_o   = cim_q;
  assign func_start_o = fs_q;

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Frame-token scheduler for the four fc_layer instances; lets
// successive frames occupy different layers concurrently.
module mlp_layer_scheduler
  import mlp_sched_pkg::*;
#(
  parameter int cim_cycles   = 16,
  parameter int out_cycles_1 = OUT_CYCLES_1,
  parameter int out_cycles_2 = OUT_CYCLES_2,
  parameter int out_cycles_3 = OUT_CYCLES_3,
  parameter int out_cycles_4 = OUT_CYCLES_4,
  parameter int cnt_w        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_out_ready,
  output logic             o_out_valid,
  input  logic [3:0]       i_layer_busy,
  output logic [3:0]       o_start,
  output logic [3:0]       o_cim_busy,
  output logic [3:0]       o_func_start,
  output logic [3:0]       o_next_busy,
  output logic             o_idle,
  output logic [cnt_w-1:0] o_frames_done
);

  localparam int OUT_CYC [NUM_LAYERS] = '{
    out_cycles_1, out_cycles_2,
    out_cycles_3, out_cycles_4
  };

  logic [NUM_LAYERS-1:0] pend_q, pend_d;
  logic [NUM_LAYERS-1:0] idle;
  logic [NUM_LAYERS-1:0] wb_done;
  logic [cnt_w-1:0]      frames_q, frames_d;
  logic                  out_valid_q;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    layer_seq_fsm #(
      .CIM_CYCLES (cim_cycles),
      .OUT_CYCLES (OUT_CYC[g]),
      .CNT_W      (cnt_w)
    ) u_fsm (
      .clk_i        (clk),
      .rst_ni       (rst),
      .pend_i       (pend_q[g]),
      .layer_busy_i (i_layer_busy[g]),
      .next_busy_i  (o_next_busy[g]),
      .idle_o       (idle[g]),
      .wb_done_o    (wb_done[g]),
      .start_o      (o_start[g]),
      .cim_busy_o   (o_cim_busy[g]),
      .func_start_o (o_func_start[g])
    );
  end

  always_comb begin
    o_next_busy = '0;
    for (int l = 0; l < NUM_LAYERS - 1; l++) begin
      o_next_busy[l] = pend_q[l+1] || !idle[l+1];
    end
    o_next_busy[NUM_LAYERS-1] = !i_out_ready;
  end

  assign o_in_ready = !pend_q[0] && idle[0];
  assign o_idle     = (&idle) && !(|pend_q);

  // Token taken by an idle layer clears; a writeback set wins.
  always_comb begin
    pend_d = pend_q & ~idle;
    if (o_in_ready && i_in_valid) pend_d[0] = 1'b1;
    for (int l = 0; l < NUM_LAYERS - 1; l++) begin
      if (wb_done[l]) pend_d[l+1] = 1'b1;
    end
  end

  assign frames_d = frames_q
    + (wb_done[NUM_LAYERS-1] ? cnt_w'(1) : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      frames_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      frames_q    <= frames_d;
      out_valid_q <= wb_done[NUM_LAYERS-1];
    end
  end

  assign o_out_valid   = out_valid_q;
  assign o_frames_done = frames_q;

endmodule

// File: tb/tb_mlp_layer_scheduler.sv
// Directed bench for mlp_layer_scheduler: latency, stall, overlap,
// async reset and frame-counter wrap.
module tb_mlp_layer_scheduler;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready;
  logic        out_ready, out_valid;
  logic [3:0]  busy, start, cim, fs, nb;
  logic        idle;
  logic [15:0] done;

  logic        w_in_valid, w_in_ready;
  logic        w_out_ready, w_out_valid;
  logic [3:0]  w_busy, w_start, w_cim, w_fs, w_nb;
  logic        w_idle;
  logic [3:0]  w_done;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  mlp_layer_scheduler #(
    .cim_cycles   (4),
    .out_cycles_1 (8),
    .out_cycles_2 (6),
    .out_cycles_3 (5),
    .out_cycles_4 (10),
    .cnt_w        (16)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_out_ready   (out_ready),
    .o_out_valid   (out_valid),
    .i_layer_busy  (busy),
    .o_start       (start),
    .o_cim_busy    (cim),
    .o_func_start  (fs),
    .o_next_busy   (nb),
    .o_idle        (idle),
    .o_frames_done (done)
  );

  mlp_layer_scheduler #(
    .cim_cycles   (1),
    .out_cycles_1 (1),
    .out_cycles_2 (1),
    .out_cycles_3 (1),
    .out_cycles_4 (1),
    .cnt_w        (4)
  ) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .i_in_valid    (w_in_valid),
    .o_in_ready    (w_in_ready),
    .i_out_ready   (w_out_ready),
    .o_out_valid   (w_out_valid),
    .i_layer_busy  (w_busy),
    .o_start       (w_start),
    .o_cim_busy    (w_cim),
    .o_func_start  (w_fs),
    .o_next_busy   (w_nb),
    .o_idle        (w_idle),
    .o_frames_done (w_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // fc_layer stand-ins: busy rises after o_start and holds N cycles.
  initial begin : model_main
    int bc [4];
    bc = '{default: 0};
    busy = '0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        if (!rst) bc[l] = 0;
        else begin
          if (bc[l] != 0) bc[l]--;
          if (start[l]) bc[l] = 5;
        end
        busy[l] = (bc[l] != 0);
      end
    end
  end

  initial begin : model_wrap
    int wc [4];
    wc = '{default: 0};
    w_busy = '0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 4; l++) begin
        if (!rst) wc[l] = 0;
        else begin
          if (wc[l] != 0) wc[l]--;
          if (w_start[l]) wc[l] = 2;
        end
        w_busy[l] = (wc[l] != 0);
      end
    end
  end

  // func_start must never follow a cycle with next_busy set.
  initial begin : mon
    logic [3:0] prev_nb;
    prev_nb = '0;
    forever begin
      @(negedge clk);
      if (rst && |(fs & prev_nb)) viol++;
      prev_nb = rst ? nb : 4'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int k);
    logic [12:0] v;
    v = {out_valid, fs, cim, start};
    return v[k];
  endfunction

  task automatic wait_lvl(input int k, input logic lvl,
                          input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (sel(k) !== lvl && n < budget);
  endtask

  initial begin : main
    int n, acc, cyc, wcnt;
    logic ok, saw3, rdy_ok;
    logic [3:0] v15;

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    w_in_valid = 1'b0;
    w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle_rdy", {idle, in_ready}, 2'b11);
    chk("rst_outs", {start, cim, fs, nb, out_valid}, 0);
    chk("rst_done", done, 0);
    chk("rst_w_idle", {w_idle, w_in_ready}, 2'b11);

    rst = 1'b1;
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("acc_pend", {in_ready, start}, 0);
    step();
    chk("start0", start, 4'b0001);
    step();
    chk("start0_pulse", start, 4'b0000);

    wait_lvl(4, 1'b1, 50, n);
    chk("cim0_lat", n, 5);
    wait_lvl(4, 1'b0, 50, n);
    chk("cim0_len", n, 4);
    chk("fs0_gap", fs, 0);
    step();
    chk("fs0", fs, 4'b0001);
    step();
    chk("fs0_pulse", fs, 0);
    wait_lvl(1, 1'b1, 50, n);
    chk("l1_start_lat", n, 8);

    out_ready = 1'b0;
    wait_lvl(7, 1'b1, 400, n);
    chk("cim3_seen", n < 400, 1);
    wait_lvl(7, 1'b0, 50, n);
    chk("cim3_len", n, 4);
    ok = 1'b1;
    repeat (5) begin
      step();
      if (fs[3] || out_valid) ok = 1'b0;
    end
    chk("stall_fs3", {ok, nb[3]}, 2'b11);
    out_ready = 1'b1;
    step();
    chk("rel_fs3", fs, 4'b1000);
    wait_lvl(12, 1'b1, 50, n);
    chk("ov_lat", n, 10);
    chk("done1", done, 1);
    step();
    chk("ov_pulse_idle", {out_valid, idle}, 2'b01);

    in_valid = 1'b1;
    acc = 0;
    cyc = 0;
    saw3 = 1'b0;
    rdy_ok = 1'b1;
    while (done < 16'd4 && cyc < 3000) begin
      if (in_valid && in_ready) acc++;
      step();
      cyc++;
      if (acc == 3) in_valid = 1'b0;
      if (cim[0] && in_ready) rdy_ok = 1'b0;
      if (!in_ready && nb[0] && nb[1]) saw3 = 1'b1;
    end
    chk("accepted3", acc, 3);
    chk("done4", done, 4);
    chk("three_conc", saw3, 1);
    chk("rdy_low_busy", rdy_ok, 1);
    chk("no_nb_viol", viol, 0);

    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_lvl(1, 1'b1, 200, n);
    chk("mid_rdy", in_ready, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_lvl(9, 1'b1, 200, n);
    chk("mid_busy", {idle, cim[0] | fs[1]}, 2'b01);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_idle_rdy", {idle, in_ready}, 2'b11);
    chk("arst_outs", {start, cim, fs, nb, out_valid}, 0);
    chk("arst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_lvl(12, 1'b1, 600, n);
    chk("fresh_ov", n < 600, 1);
    chk("fresh_done", done, 1);

    w_in_valid = 1'b1;
    wcnt = 0;
    cyc = 0;
    v15 = '0;
    while (wcnt < 16 && cyc < 4000) begin
      step();
      cyc++;
      if (w_out_valid) begin
        wcnt++;
        if (wcnt == 15) v15 = w_done;
      end
    end
    w_in_valid = 1'b0;
    chk("wrap_cnt", wcnt, 16);
    chk("wrap_max", v15, 4'hF);
    chk("wrap_zero", w_done, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
